// File: rtl/repeat_scan_ctrl_pkg.sv
// Shared types for the repeat_scan_ctrl slice: controller FSM states and requester ids.
package repeat_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/repeat_detector.sv
// Serial repeated-bit detector: flags a bit equal to the previous enabled bit.
module repeat_detector (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic in_bit,
  output logic out_bit
);

  logic prev_bit_q;
  logic have_prev_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prev_bit_q  <= 1'b0;
      have_prev_q <= 1'b0;
    end else if (en) begin
      prev_bit_q  <= in_bit;
      have_prev_q <= 1'b1;
    end
  end

  // Mealy output: the hit is visible in the same cycle the bit is presented.
  assign out_bit = en & have_prev_q & (in_bit == prev_bit_q);

endmodule

// File: rtl/repeat_scan_ctrl.sv
// Round-robin front end that serialises words from two requesters through one
// repeat_detector and reports the per-word repeat count tagged with the requester id.
module repeat_scan_ctrl
  import repeat_scan_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_id,
  output logic [CNT_W-1:0] res_count,
  output logic             busy
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [IdxW-1:0]  bit_idx_q;
  logic [CNT_W-1:0] count_q;
  logic             last_grant_q;
  logic             id_q;
  logic             res_valid_q;
  logic             res_id_q;
  logic [CNT_W-1:0] res_count_q;

  logic             idle_ok;
  logic             hs0;
  logic             hs1;
  logic             det_clr;
  logic             det_en;
  logic             det_hit;
  logic [CNT_W-1:0] count_next;

  // On contention the requester that did not win last time gets the grant.
  assign idle_ok    = (state_q == StIdle) && !rst;
  assign req0_ready = idle_ok && req0_valid && (!req1_valid || (last_grant_q == REQ1));
  assign req1_ready = idle_ok && req1_valid && (!req0_valid || (last_grant_q == REQ0));

  assign hs0 = req0_valid && req0_ready;
  assign hs1 = req1_valid && req1_ready;

  assign det_clr    = hs0 || hs1;
  assign det_en     = (state_q == StShift);
  assign count_next = count_q + CNT_W'(det_hit);

  repeat_detector u_detector (
    .clk     (clk),
    .rst     (rst),
    .clr     (det_clr),
    .en      (det_en),
    .in_bit  (shreg_q[0]),
    .out_bit (det_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      count_q      <= '0;
      last_grant_q <= REQ1;
      id_q         <= REQ0;
      res_valid_q  <= 1'b0;
      res_id_q     <= REQ0;
      res_count_q  <= '0;
    end else begin
      res_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (hs0 || hs1) begin
            shreg_q      <= hs1 ? req1_data : req0_data;
            bit_idx_q    <= '0;
            count_q      <= '0;
            last_grant_q <= hs1;
            id_q         <= hs1;
            state_q      <= StShift;
          end
        end
        StShift: begin
          count_q   <= count_next;
          shreg_q   <= shreg_q >> 1;
          bit_idx_q <= bit_idx_q + IdxW'(1);
          if (bit_idx_q == LastIdx) begin
            res_valid_q <= 1'b1;
            res_id_q    <= id_q;
            res_count_q <= count_next;
            state_q     <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_count = res_count_q;
  assign busy      = (state_q == StShift) || (state_q == StDone);

endmodule

// File: tb/tb_repeat_scan_ctrl.sv
// Directed bench for repeat_scan_ctrl: stimulus pushes expected results, a monitor pops and checks.
module tb_repeat_scan_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             res_valid;
  logic             res_id;
  logic [CNT_W-1:0] res_count;
  logic             busy;

  repeat_scan_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_count  (res_count),
    .busy       (busy)
  );

  typedef struct {
    int id;
    int cnt;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   watch_r0 = 0;
  bit   r0_seen  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (watch_r0 && req0_ready) r0_seen = 1'b1;
    if (!rst && res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_res: got res_valid=1 id=%0d count=%0d expected none (cycle %0d)",
                 res_id, res_count, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_id", int'(res_id), e.id);
        chk("res_count", int'(res_count), e.cnt);
        chk("res_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input bit id, input logic [WIDTH-1:0] d, input int exp_cnt);
    bit got;
    int n;
    got = 0;
    n = 0;
    @(posedge clk) #1;
    if (id) begin
      req1_valid = 1'b1;
      req1_data  = d;
    end else begin
      req0_valid = 1'b1;
      req0_data  = d;
    end
    while (!got && n < 50) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) got = 1;
      else n++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout: got no ready expected ready for requester %0d", id);
    end else begin
      exp_q.push_back('{id: int'(id), cnt: exp_cnt, cyc: cyc + WIDTH + 1});
    end
    @(posedge clk) #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk) #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int prev_hs;
    bit got;
    int n;
    rst        = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = '0;
    req1_data  = '0;

    // Reset state, with both requesters valid so ready gating by rst is exercised.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", int'(req0_ready), 0);
    chk("rst_req1_ready", int'(req1_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_res_count", int'(res_count), 0);
    @(posedge clk) #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst        = 1'b0;

    // Scenario 1: all zeros from requester 0.
    send(1'b0, 8'h00, 7);
    chk("s1_busy", int'(busy), 1);
    wait_drain();

    // Scenario 2: requester 1 alone, alternating bits; req0_ready must never rise.
    watch_r0 = 1'b1;
    r0_seen  = 1'b0;
    send(1'b1, 8'h55, 0);
    wait_drain();
    watch_r0 = 1'b0;
    chk("s2_req0_ready_seen", int'(r0_seen), 0);

    // Scenario 3
    send(1'b0, 8'h33, 4);
    wait_drain();

    // Scenario 4: both requesters valid continuously from reset.
    do_reset();
    req0_data  = 8'hFF;
    req1_data  = 8'h00;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    prev_hs    = 0;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      n   = 0;
      while (!got && n < 30) begin
        @(negedge clk);
        if (req0_ready || req1_ready) got = 1;
        else n++;
      end
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL s4_grant_timeout: got no ready expected grant %0d", k);
      end else begin
        chk("s4_both_ready", int'(req0_ready & req1_ready), 0);
        chk("s4_grant_id", int'(req1_ready), k % 2);
        if (k > 0) chk("s4_spacing", cyc - prev_hs, WIDTH + 2);
        prev_hs = cyc;
        exp_q.push_back('{id: int'(req1_ready), cnt: 7, cyc: cyc + WIDTH + 1});
      end
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain();

    // Scenario 5: back-to-back words must not pair bits across the boundary.
    send(1'b0, 8'h80, 6);
    send(1'b0, 8'h01, 6);
    wait_drain();

    // Scenario 6: reset pulse during the 4th SHIFT cycle discards the word.
    @(posedge clk) #1;
    req0_valid = 1'b1;
    req0_data  = 8'h00;
    got = 0;
    n   = 0;
    while (!got && n < 30) begin
      @(negedge clk);
      if (req0_ready) got = 1;
      else n++;
    end
    chk("s6_first_hs", int'(got), 1);
    @(posedge clk) #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst        = 1'b1;
    req0_valid = 1'b1;
    @(negedge clk);
    chk("s6_ready_in_rst", int'(req0_ready), 0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s6_busy_after_rst", int'(busy), 0);
    chk("s6_res_valid_after_rst", int'(res_valid), 0);
    chk("s6_ready_after_rst", int'(req0_ready), 1);
    if (req0_ready) exp_q.push_back('{id: 0, cnt: 7, cyc: cyc + WIDTH + 1});
    @(posedge clk) #1;
    req0_valid = 1'b0;
    wait_drain();
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/repeat_scan_ctrl.md
Name: repeat_scan_ctrl

Overview:
Controller that shares one serial repeated-bit detector between two parallel-word requesters. It grants requesters round-robin, accepts a WIDTH-bit word through a valid/ready handshake and shifts it LSB-first into the detector, one bit per cycle. It counts the detector's repeat hits and returns a per-word result tagged with the requester id. It sits between word-oriented producers and the bit-serial detection datapath.

Parameters:
WIDTH, 8, bits per word; must be at least 2.
CNT_W, 4, width of the repeat count; must satisfy 2**CNT_W > WIDTH-1.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset, synchronous and active-high; sampled on the clk rising edge.
req0_valid  in  1  requester 0 has a word.
req0_data  in  WIDTH  requester 0 word.
req0_ready  out  1  requester 0 word accepted this cycle when req0_valid is also high.
req1_valid  in  1  requester 1 has a word.
req1_data  in  WIDTH  requester 1 word.
req1_ready  out  1  requester 1 word accepted this cycle when req1_valid is also high.
res_valid  out  1  one-cycle pulse: result fields are new.
res_id  out  1  requester index of the result.
res_count  out  CNT_W  number of repeat hits in the word.
busy  out  1  high in SHIFT and DONE.

Behaviour:
- FSM states are IDLE, SHIFT and DONE. The state register, shift register, bit index, count, last_grant and result fields are all registered.
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins first), res_valid=0, res_id=0, res_count=0, busy=0. The detector is also reset.
- IDLE, ready generation: ready is combinational and high only in IDLE, for the granted requester only.
  - Grant goes to the sole valid requester.
  - If both requesters are valid, grant goes to the one that is not last_grant.
  - The ungranted requester's ready stays 0.
- IDLE, on handshake (valid & ready):
  - load the shift register with the word;
  - set bit_idx=0, count=0, last_grant=granted id;
  - latch the id;
  - assert detector clr for that cycle;
  - go to SHIFT.
- SHIFT: each cycle, drive shreg[0] into the detector with en=1.
  - If the detector's Mealy output is 1, count increments.
  - Shift right and increment bit_idx.
  - At bit_idx==WIDTH-1, take the final bit's hit into account and go to DONE.
- DONE: the cycle after the last bit, res_valid=1 and res_id/res_count update. Then return to IDLE.
  - res_id and res_count hold their values until the next DONE.
- Detector sub-module, Mealy: out = en & have_prev & (in_bit == prev_bit).
  - prev_bit and have_prev update when en=1.
  - clr or rst sets have_prev=0.
  - The first bit of every word never hits, so no repeat is counted across word boundaries.
- Timing: handshake at edge T; bits are presented in cycles T+1..T+WIDTH; res_valid is high in cycle T+WIDTH+1. The next handshake is possible in cycle T+WIDTH+2 (WIDTH+2 cycles per word).
- Count width: the maximum count is WIDTH-1. No saturation logic is required, given the parameter constraint.
- Data stability: requester data must be stable while valid is high. Withdrawing valid before a grant is legal and is ignored.
- Reset mid-operation (SHIFT or DONE): return to IDLE and discard the word. No res_valid is produced. All values return to reset values.
- When rst is high, ready is 0.

Decomposition:
- Shared package: FSM state encodings (IDLE, SHIFT, DONE) and the requester id constants (REQ0=0, REQ1=1).
- One sub-module: repeat_detector (clk, rst, clr, en, in_bit, out_bit), instantiated once.

Test Plan:
- Scenario 1: req0_valid with 8'h00, handshake at T -> res_valid only in cycle T+9; res_id=0, res_count=7.
- Scenario 2: req1_valid only, 8'h55 (alternating bits) -> res_id=1, res_count=0; req0_ready stays 0 throughout.
- Scenario 3: req0 with 8'h33 (LSB-first bits 1,1,0,0,1,1,0,0) -> res_count=4.
- Scenario 4: both valid continuously, req0=8'hFF, req1=8'h00, from reset -> grant order 0,1,0,1; each res_count=7; handshakes spaced exactly 10 cycles apart.
- Scenario 5: req0 sends 8'h80 then 8'h01 back to back -> counts 6 and 6. The last bit 1 of the first word must not pair with the first bit 1 of the second word.
- Scenario 6: rst asserted for one cycle during the 4th SHIFT cycle -> no res_valid, busy=0. req0_ready returns high in the cycle after rst deasserts (with req0_valid high). A following 8'h00 returns res_count=7.
